unified_mem_arbiter: RTL and testbench

//  Shares one single-ported word memory between instruction fetch (read-only, word) and the

---
 rtl/unified_mem_arbiter_pkg.sv | 33 +++
 rtl/unified_mem_arbiter_load_store_align.sv | 58 +++++
 rtl/unified_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg
//   Shared definitions for the unified memory arbiter:
//   - FSM state encodings (IDLE / BUSY_F / BUSY_D)
//   - data access size codes (byte=0, half=1, word=3; 2 is illegal)
//   - word returned to fetch when a fetch times out (NOP)
//   - helper that flags misaligned or illegal-size data requests
package unified_mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_F = 2'd1;
    localparam logic [1:0] ST_BUSY_D = 2'd2;

    localparam logic [1:0] MEM_SIZE_BYTE    = 2'd0;
    localparam logic [1:0] MEM_SIZE_HALF    = 2'd1;
    localparam logic [1:0] MEM_SIZE_ILLEGAL = 2'd2;
    localparam logic [1:0] MEM_SIZE_WORD    = 2'd3;

    // addi x0,x0,0 -- harmless instruction handed back on a fetch timeout
    localparam logic [31:0] FETCH_TIMEOUT_WORD = 32'h0000_0013;

    // 1 when the access cannot be issued to memory as a single aligned word access
    function automatic logic d_req_bad(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        case (size)
            MEM_SIZE_BYTE: bad = 1'b0;
            MEM_SIZE_HALF: bad = lo[0];
            MEM_SIZE_WORD: bad = (lo != 2'b00);
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_load_store_align.sv
// load_store_align
//   Combinational lane steering between a 32-bit memory word and the LSU.
//   Load side : picks the byte/half addressed by lane_i out of rword_i and
//               zero- or sign-extends it to 32 bits.
//   Store side: builds byte strobes and replicates right-aligned store data
//               into every lane so the strobes alone select what is written.
// Ports
//   size_i   in  2   access size code
//   lane_i   in  2   byte address bits [1:0]
//   sext_i   in  1   sign-extend load result
//   rword_i  in  32  raw memory read word
//   wdata_i  in  32  right-aligned store data
//   rdata_o  out 32  aligned/extended load data (0 for illegal size)
//   wstrb_o  out 4   byte lane strobes
//   wdata_o  out 32  lane-replicated store data
module load_store_align
    import unified_mem_arbiter_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        sext_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v  = rword_i[8*lane_i +: 8];
        half_v  = rword_i[16*lane_i[1] +: 16];
        rdata_o = 32'h0;
        wstrb_o = 4'h0;
        wdata_o = 32'h0;
        case (size_i)
            MEM_SIZE_BYTE: begin
                rdata_o = {{24{sext_i & byte_v[7]}}, byte_v};
                wstrb_o = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MEM_SIZE_HALF: begin
                rdata_o = {{16{sext_i & half_v[15]}}, half_v};
                wstrb_o = 4'b0011 << {lane_i[1], 1'b0};
                wdata_o = {2{wdata_i[15:0]}};
            end
            MEM_SIZE_WORD: begin
                rdata_o = rword_i;
                wstrb_o = 4'hF;
                wdata_o = wdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-ported word memory between instruction fetch and the
//   load/store path. One transaction at a time; grants only in IDLE.
//   Data wins arbitration unless fetch has waited through STREAK_MAX data
//   grants in a row. Misaligned / illegal-size data requests are answered
//   with d_err one cycle after the grant without touching memory.
// Build option
//   ARB_TIMEOUT_EN : when defined, a transaction that sees no mem_ready for
//                    TIMEOUT_CYCLES busy cycles is aborted (data: d_err=1,
//                    rdata 0; fetch: returns a NOP word). Undefined: wait forever.
// Ports
//   clock, reset           single clock, synchronous active-high reset
//   f_req/f_addr           fetch request (word read)
//   f_gnt/f_rvalid/f_rdata fetch accept (comb), completion pulse, instruction
//   d_req/d_addr/d_wr_en/d_size_sel/d_sign_ext/d_wdata   data request
//   d_gnt/d_rvalid/d_rdata/d_err                         data accept, completion
//   mem_req/mem_addr/mem_we/mem_wstrb/mem_wdata          memory command
//   mem_rdata/mem_ready                                  memory response
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int STREAK_MAX     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_rvalid,
    output logic [31:0] f_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_wr_en,
    input  logic [1:0]  d_size_sel,
    input  logic        d_sign_ext,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int SW = $clog2(STREAK_MAX + 1);

    logic [1:0]    state_q, state_d;
    logic [31:0]   addr_q;
    logic          we_q;
    logic [1:0]    size_q;
    logic          sext_q;
    logic [31:0]   wdata_q;
    logic [SW-1:0] streak_q;
    logic          f_rvalid_q, d_rvalid_q, d_err_q;
    logic [31:0]   f_rdata_q, d_rdata_q;

    logic          idle, d_bad, tmo_hit;
    logic [31:0]   ld_rdata, st_wdata;
    logic [3:0]    st_wstrb;

    // ---------------------------------------------------------------- arbitration
    assign idle  = (state_q == ST_IDLE) && !reset;
    assign d_bad = d_req_bad(d_size_sel, d_addr[1:0]);
    assign d_gnt = idle && d_req && !(f_req && (streak_q == SW'(STREAK_MAX)));
    assign f_gnt = idle && f_req && !d_gnt;

    // Counts data grants fetch has lost in a row; any gap in f_req forgives it.
    always_ff @(posedge clock) begin
        if (reset || !f_req || f_gnt)
            streak_q <= '0;
        else if (d_gnt && (streak_q != SW'(STREAK_MAX)))
            streak_q <= streak_q + SW'(1);
    end

    // ---------------------------------------------------------------- timeout
`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q;

    // Fires on the last allowed busy cycle so IDLE is reached exactly
    // TIMEOUT_CYCLES cycles after the busy state was entered.
    assign tmo_hit = (state_q != ST_IDLE) && !mem_ready && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || (state_q == ST_IDLE))
            tmo_q <= '0;
        else if (!mem_ready)
            tmo_q <= tmo_q + TW'(1);
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (d_gnt && !d_bad) state_d = ST_BUSY_D;
                else if (f_gnt)      state_d = ST_BUSY_F;
            end
            ST_BUSY_F, ST_BUSY_D: begin
                if (mem_ready || tmo_hit) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= 32'h0;
            we_q       <= 1'b0;
            size_q     <= MEM_SIZE_WORD;
            sext_q     <= 1'b0;
            wdata_q    <= 32'h0;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            f_rdata_q  <= 32'h0;
            d_rdata_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            f_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (d_gnt) begin
                        addr_q  <= d_addr;
                        we_q    <= d_wr_en;
                        size_q  <= d_size_sel;
                        sext_q  <= d_sign_ext;
                        wdata_q <= d_wdata;
                        // Rejected requests complete immediately, memory untouched.
                        if (d_bad) begin
                            d_rvalid_q <= 1'b1;
                            d_err_q    <= 1'b1;
                            d_rdata_q  <= 32'h0;
                        end
                    end else if (f_gnt) begin
                        addr_q <= f_addr;
                        we_q   <= 1'b0;
                        size_q <= MEM_SIZE_WORD;
                        sext_q <= 1'b0;
                    end
                end
                ST_BUSY_F: begin
                    if (mem_ready) begin
                        f_rvalid_q <= 1'b1;
                        f_rdata_q  <= mem_rdata;
                    end else if (tmo_hit) begin
                        f_rvalid_q <= 1'b1;
                        f_rdata_q  <= FETCH_TIMEOUT_WORD;
                    end
                end
                ST_BUSY_D: begin
                    if (mem_ready) begin
                        d_rvalid_q <= 1'b1;
                        d_rdata_q  <= we_q ? 32'h0 : ld_rdata;
                    end else if (tmo_hit) begin
                        d_rvalid_q <= 1'b1;
                        d_err_q    <= 1'b1;
                        d_rdata_q  <= 32'h0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------- lanes
    load_store_align u_align (
        .size_i  (size_q),
        .lane_i  (addr_q[1:0]),
        .sext_i  (sext_q),
        .rword_i (mem_rdata),
        .wdata_i (wdata_q),
        .rdata_o (ld_rdata),
        .wstrb_o (st_wstrb),
        .wdata_o (st_wdata)
    );

    // ---------------------------------------------------------------- outputs
    assign mem_req   = (state_q != ST_IDLE);
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_we    = (state_q == ST_BUSY_D) && we_q;
    assign mem_wstrb = mem_we ? st_wstrb : 4'h0;
    assign mem_wdata = mem_we ? st_wdata : 32'h0;

    assign f_rvalid  = f_rvalid_q;
    assign f_rdata   = f_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        f_req = 1'b0;
    logic [31:0] f_addr = 32'h0;
    logic        f_gnt, f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic        d_wr_en = 1'b0;
    logic [1:0]  d_size_sel = 2'd3;
    logic        d_sign_ext = 1'b0;
    logic [31:0] d_wdata = 32'h0;
    logic        d_gnt, d_rvalid, d_err;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;

    unified_mem_arbiter dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wr_en(d_wr_en), .d_size_sel(d_size_sel),
        .d_sign_ext(d_sign_ext), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] wd;
        logic [31:0] rw;
        logic [31:0] e_rd;
        logic        e_err;
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
    } vec_t;

    typedef struct {
        logic        ok;
        logic [31:0] rd;
        logic        err;
        logic        seen_req;
        logic [31:0] maddr;
        logic        mwe;
        logic [3:0]  strb;
        logic [31:0] mwd;
        int          lat;
    } obs_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; f_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // One request on the fetch (is_f) or data port; the memory answers
    // 'lat' busy cycles after mem_req first appears. o.lat counts cycles from
    // the grant cycle to the rvalid cycle.
    task automatic txn(input bit is_f, input logic we, input logic [31:0] a, input logic [1:0] sz,
                       input logic sx, input logic [31:0] wd, input logic [31:0] rw,
                       input int lat, output obs_t o);
        int  busy;
        logic g;
        o.ok = 0; o.rd = 0; o.err = 0; o.seen_req = 0; o.maddr = 0;
        o.mwe = 0; o.strb = 0; o.mwd = 0; o.lat = 0;
        @(negedge clock);
        if (is_f) begin f_req = 1'b1; f_addr = a; end
        else begin
            d_req = 1'b1; d_addr = a; d_wr_en = we; d_size_sel = sz; d_sign_ext = sx; d_wdata = wd;
        end
        #1;
        g = is_f ? f_gnt : d_gnt;
        for (int i = 0; i < 50 && !g; i++) begin
            @(negedge clock); #1;
            g = is_f ? f_gnt : d_gnt;
        end
        if (!g) begin f_req = 1'b0; d_req = 1'b0; return; end
        @(negedge clock);
        f_req = 1'b0; d_req = 1'b0; busy = 0; o.lat = 1;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (is_f ? f_rvalid : d_rvalid) begin
                o.rd  = is_f ? f_rdata : d_rdata;
                o.err = is_f ? 1'b0 : d_err;
                o.ok  = 1'b1;
                break;
            end
            if (mem_req) begin
                o.seen_req = 1'b1; o.maddr = mem_addr; o.mwe = mem_we;
                o.strb = mem_wstrb; o.mwd = mem_wdata;
                if (busy == lat) begin mem_ready = 1'b1; mem_rdata = rw; end
                busy++;
            end
            @(negedge clock);
            mem_ready = 1'b0;
            o.lat++;
        end
    endtask

    // Reference: what the spec says a single data access must produce.
    function automatic vec_t ref_model(input vec_t v);
        vec_t r;
        int lane, hsel;
        logic [31:0] x;
        r = v;
        lane = int'(v.a[1:0]);
        hsel = int'(v.a[1]);
        r.e_err = (v.sz == 2'd2) || (v.sz == 2'd1 && (v.a % 2) != 0) || (v.sz == 2'd3 && (v.a % 4) != 0);
        r.e_rd = 0; r.e_strb = 0; r.e_wd = 0;
        if (!r.e_err) begin
            if (v.we) begin
                case (v.sz)
                    2'd0: begin r.e_strb = 4'(1 << lane);        r.e_wd = (v.wd & 32'hFF)   * 32'h01010101; end
                    2'd1: begin r.e_strb = 4'(3 << (2 * hsel));  r.e_wd = (v.wd & 32'hFFFF) * 32'h00010001; end
                    default: begin r.e_strb = 4'hF;              r.e_wd = v.wd; end
                endcase
            end else begin
                case (v.sz)
                    2'd0: begin
                        x = (v.rw >> (8 * lane)) & 32'hFF;
                        if (v.sx && x >= 32'd128) x = x - 32'd256;
                    end
                    2'd1: begin
                        x = (v.rw >> (16 * hsel)) & 32'hFFFF;
                        if (v.sx && x >= 32'd32768) x = x - 32'd65536;
                    end
                    default: x = v.rw;
                endcase
                r.e_rd = x;
            end
        end
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input int lat, input string tag);
        obs_t o;
        txn(1'b0, v.we, v.a, v.sz, v.sx, v.wd, v.rw, lat, o);
        chk({tag, " done"}, 32'(o.ok), 32'd1);
        chk({tag, " err"}, 32'(o.err), 32'(v.e_err));
        chk({tag, " rdata"}, o.rd, v.e_rd);
        chk({tag, " mem_req"}, 32'(o.seen_req), 32'(!v.e_err));
        if (!v.e_err) begin
            chk({tag, " mem_addr"}, o.maddr, v.a & 32'hFFFF_FFFC);
            chk({tag, " mem_we"}, 32'(o.mwe), 32'(v.we));
            chk({tag, " wstrb"}, 32'(o.strb), 32'(v.e_strb));
            if (v.we) chk({tag, " wdata"}, o.mwd, v.e_wd);
            chk({tag, " latency"}, o.lat, lat + 2);
        end else begin
            chk({tag, " latency"}, o.lat, 1);
        end
    endtask

    initial begin
        obs_t  o;
        vec_t  v;
        string pat;
        int    both, rv_seen;

        //            we    addr         sz    sx    wdata         mem word      exp rdata     err   strb   exp wdata
        vecs[0]  = '{1'b0, 32'h203, 2'd0, 1'b1, 32'h0,        32'h80FFFFFF, 32'hFFFFFF80, 1'b0, 4'h0, 32'h0};
        vecs[1]  = '{1'b0, 32'h203, 2'd0, 1'b0, 32'h0,        32'h80FFFFFF, 32'h00000080, 1'b0, 4'h0, 32'h0};
        vecs[2]  = '{1'b0, 32'h202, 2'd1, 1'b1, 32'h0,        32'h80FFFFFF, 32'hFFFF80FF, 1'b0, 4'h0, 32'h0};
        vecs[3]  = '{1'b0, 32'h200, 2'd1, 1'b0, 32'h0,        32'h1234ABCD, 32'h0000ABCD, 1'b0, 4'h0, 32'h0};
        vecs[4]  = '{1'b0, 32'h200, 2'd1, 1'b1, 32'h0,        32'h1234ABCD, 32'hFFFFABCD, 1'b0, 4'h0, 32'h0};
        vecs[5]  = '{1'b0, 32'h201, 2'd0, 1'b1, 32'h0,        32'h1234ABCD, 32'hFFFFFFAB, 1'b0, 4'h0, 32'h0};
        vecs[6]  = '{1'b0, 32'h206, 2'd1, 1'b1, 32'h0,        32'h7FFF0000, 32'h00007FFF, 1'b0, 4'h0, 32'h0};
        vecs[7]  = '{1'b0, 32'h204, 2'd3, 1'b0, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4'h0, 32'h0};
        vecs[8]  = '{1'b0, 32'h101, 2'd3, 1'b0, 32'h0,        32'hDEADBEEF, 32'h0,        1'b1, 4'h0, 32'h0};
        vecs[9]  = '{1'b0, 32'h203, 2'd1, 1'b0, 32'h0,        32'hDEADBEEF, 32'h0,        1'b1, 4'h0, 32'h0};
        vecs[10] = '{1'b0, 32'h200, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 32'h0,        1'b1, 4'h0, 32'h0};
        vecs[11] = '{1'b1, 32'h302, 2'd1, 1'b0, 32'h0000BEEF, 32'h0,        32'h0,        1'b0, 4'hC, 32'hBEEFBEEF};
        vecs[12] = '{1'b1, 32'h301, 2'd0, 1'b0, 32'h123456A5, 32'h0,        32'h0,        1'b0, 4'h2, 32'hA5A5A5A5};
        vecs[13] = '{1'b1, 32'h300, 2'd3, 1'b0, 32'hCAFEF00D, 32'h0,        32'h0,        1'b0, 4'hF, 32'hCAFEF00D};
        vecs[14] = '{1'b1, 32'h303, 2'd0, 1'b0, 32'h00000077, 32'h0,        32'h0,        1'b0, 4'h8, 32'h77777777};
        vecs[15] = '{1'b1, 32'h301, 2'd1, 1'b0, 32'h0000BEEF, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0};

        // ---- reset state
        do_reset();
        #1;
        chk("reset f_rvalid", 32'(f_rvalid), 32'd0);
        chk("reset d_rvalid", 32'(d_rvalid), 32'd0);
        chk("reset d_err", 32'(d_err), 32'd0);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        chk("reset mem_we", 32'(mem_we), 32'd0);
        chk("reset mem_wstrb", 32'(mem_wstrb), 32'd0);
        chk("reset f_rdata", f_rdata, 32'd0);
        chk("reset d_rdata", d_rdata, 32'd0);

        // ---- fetch 0x100, memory answers after 3 waiting cycles
        txn(1'b1, 1'b0, 32'h100, 2'd3, 1'b0, 32'h0, 32'h00500093, 3, o);
        chk("fetch done", 32'(o.ok), 32'd1);
        chk("fetch rdata", o.rd, 32'h00500093);
        chk("fetch latency", o.lat, 5);
        chk("fetch mem_addr", o.maddr, 32'h100);
        chk("fetch mem_we", 32'(o.mwe), 32'd0);
        chk("fetch wstrb", 32'(o.strb), 32'd0);

        // ---- table of loads / stores / rejected accesses
        for (int i = 0; i < 16; i++) run_vec(vecs[i], i % 3, $sformatf("vec%0d", i));

        // ---- both requesters held high: D,D,D,D,F repeating
        do_reset();
        @(negedge clock);
        f_req = 1'b1; f_addr = 32'h500;
        d_req = 1'b1; d_addr = 32'h600; d_wr_en = 1'b0; d_size_sel = 2'd3; d_sign_ext = 1'b0;
        pat = ""; both = 0;
        for (int c = 0; c < 100 && pat.len() < 10; c++) begin
            #1;
            if (f_gnt && d_gnt) both++;
            if (d_gnt) pat = {pat, "D"};
            else if (f_gnt) pat = {pat, "F"};
            mem_ready = mem_req; mem_rdata = 32'h1;
            @(negedge clock);
        end
        f_req = 1'b0; d_req = 1'b0;
        for (int c = 0; c < 4; c++) begin #1; mem_ready = mem_req; @(negedge clock); end
        mem_ready = 1'b0;
        chk("arb no double grant", both, 0);
        n_chk++;
        if (pat != "DDDDFDDDDF") begin
            n_fail++;
            $display("FAIL arb pattern: got %s, expected DDDDFDDDDF", pat);
        end

        // ---- reset while BUSY_D drops the transaction silently
        do_reset();
        @(negedge clock);
        d_req = 1'b1; d_addr = 32'h400; d_wr_en = 1'b0; d_size_sel = 2'd3;
        #1;
        chk("rst-busy gnt", 32'(d_gnt), 32'd1);
        @(negedge clock);
        d_req = 1'b0;
        #1;
        chk("rst-busy mem_req", 32'(mem_req), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("rst-busy mem_req drop", 32'(mem_req), 32'd0);
        reset = 1'b0;
        rv_seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock); #1;
            if (d_rvalid) rv_seen++;
            mem_ready = 1'b1;
        end
        mem_ready = 1'b0;
        chk("rst-busy no d_rvalid", rv_seen, 0);

`ifdef ARB_TIMEOUT_EN
        // ---- memory never answers
        txn(1'b0, 1'b0, 32'h700, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF, 100000, o);
        chk("tmo data done", 32'(o.ok), 32'd1);
        chk("tmo data err", 32'(o.err), 32'd1);
        chk("tmo data rdata", o.rd, 32'h0);
        chk("tmo data latency", o.lat, 65);
        txn(1'b1, 1'b0, 32'h800, 2'd3, 1'b0, 32'h0, 32'hFFFFFFFF, 100000, o);
        chk("tmo fetch done", 32'(o.ok), 32'd1);
        chk("tmo fetch rdata", o.rd, 32'h00000013);
        chk("tmo fetch latency", o.lat, 65);
`endif

        // ---- randomized accesses against the reference model
        for (int i = 0; i < 40; i++) begin
            int lat;
            lat = $urandom_range(0, 3);
            if ($urandom_range(0, 4) == 0) begin
                logic [31:0] w;
                w = $urandom;
                txn(1'b1, 1'b0, 32'h2000 + 32'($urandom_range(0, 255)), 2'd3, 1'b0, 32'h0, w, lat, o);
                chk($sformatf("rnd%0d fetch rdata", i), o.rd, w);
                chk($sformatf("rnd%0d fetch latency", i), o.lat, lat + 2);
            end else begin
                v.we = 1'($urandom_range(0, 1));
                v.a  = 32'h1000 + 32'($urandom_range(0, 255));
                v.sz = 2'($urandom_range(0, 3));
                v.sx = 1'($urandom_range(0, 1));
                v.wd = $urandom;
                v.rw = $urandom;
                v = ref_model(v);
                run_vec(v, lat, $sformatf("rnd%0d", i));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
